// File: rtl/csr_pkg.sv
// Shared constants and helpers for the machine-mode CSR file.
// Holds the CSR address map, the mstatus bit positions, the fixed misa
// value and the bit order of the one-hot CSR operation vector. The decode
// stage imports the same package, so both sides agree on every encoding.
package csr_pkg;

  localparam int XLEN = 64;

  // CSR address map
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mstatus layout: only MIE and MPIE are stored, MPP reads as machine mode
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [XLEN-1:0] MSTATUS_FIXED = 64'h0000_0000_0000_1800;

  // RV64 with the I extension only
  localparam logic [XLEN-1:0] MISA_VALUE = 64'h8000_0000_0000_0100;

  // Bit positions inside the one-hot wr_op_i vector
  localparam int OP_CSRRW  = 5;
  localparam int OP_CSRRS  = 4;
  localparam int OP_CSRRC  = 3;
  localparam int OP_CSRRWI = 2;
  localparam int OP_CSRRSI = 1;
  localparam int OP_CSRRCI = 0;

  // Register and immediate forms collapse onto the same update kind
  typedef enum logic [1:0] {
    OPK_NONE  = 2'd0,
    OPK_WRITE = 2'd1,
    OPK_SET   = 2'd2,
    OPK_CLEAR = 2'd3
  } op_kind_e;

  function automatic op_kind_e decode_op(input logic [5:0] op);
    op_kind_e kind;
    kind = OPK_NONE;
    if (op[OP_CSRRW] || op[OP_CSRRWI]) kind = OPK_WRITE;
    else if (op[OP_CSRRS] || op[OP_CSRRSI]) kind = OPK_SET;
    else if (op[OP_CSRRC] || op[OP_CSRRCI]) kind = OPK_CLEAR;
    return kind;
  endfunction

  function automatic logic csr_implemented(input logic [11:0] idx);
    logic hit;
    case (idx)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
      CSR_MHARTID: hit = 1'b1;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr.sv
// Machine-mode CSR file for a single-hart RV64I core.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   rd_idx_i             - read address from decode (instr[31:20])
//   rd_data_o            - combinational read data (value before any update)
//   rd_illegal_o         - read address is not an implemented CSR
//   wr_en_i              - a CSR instruction commits this cycle
//   wr_idx_i             - CSR write address
//   wr_op_i              - one-hot {csrrw,csrrs,csrrc,csrrwi,csrrsi,csrrci}
//   wr_src_i             - rs1 value or zero-extended zimm
//   wr_src_zero_i        - rs1 index / zimm is zero
//   retire_i             - one instruction retires this cycle
//   trap_i, trap_pc_i, trap_cause_i, trap_tval_i - trap entry
//   mret_i               - mret commits this cycle
//   trap_vec_o           - mtvec
//   mret_pc_o            - mepc
//   mstatus_mie_o        - mstatus.MIE
module csr
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     rd_idx_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_illegal_o,
  input  logic            wr_en_i,
  input  logic [11:0]     wr_idx_i,
  input  logic [5:0]      wr_op_i,
  input  logic [XLEN-1:0] wr_src_i,
  input  logic            wr_src_zero_i,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mret_pc_o,
  output logic            mstatus_mie_o
);

  logic            mstatus_mie_q,  mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q,      mie_d;
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic [XLEN-1:0] mtval_q,    mtval_d;
  logic [XLEN-1:0] mcycle_q,   mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  op_kind_e        op_kind;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_new;
  logic            wr_ok;

  // Architectural read view of every CSR; unimplemented addresses read 0.
  // mtvec and mepc keep their low two bits clear at write time.
  function automatic logic [XLEN-1:0] csr_read(input logic [11:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    case (idx)
      CSR_MSTATUS: begin
        v                   = MSTATUS_FIXED;
        v[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        v[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
      end
      CSR_MISA:     v = MISA_VALUE;
      CSR_MIE:      v = mie_q;
      CSR_MTVEC:    v = mtvec_q;
      CSR_MSCRATCH: v = mscratch_q;
      CSR_MEPC:     v = mepc_q;
      CSR_MCAUSE:   v = mcause_q;
      CSR_MTVAL:    v = mtval_q;
      CSR_MCYCLE:   v = mcycle_q;
      CSR_MINSTRET: v = minstret_q;
      default:      v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    rd_data_o    = csr_read(rd_idx_i);
    rd_illegal_o = !csr_implemented(rd_idx_i);
  end

  // Single shared new-value computation used by every writable register.
  // Set/clear with a zero source are reads only, so they never write.
  // Trap and mret own the cycle, which drops any same-cycle CSR write.
  always_comb begin
    op_kind = decode_op(wr_op_i);
    wr_old  = csr_read(wr_idx_i);
    case (op_kind)
      OPK_WRITE: wr_new = wr_src_i;
      OPK_SET:   wr_new = wr_old | wr_src_i;
      OPK_CLEAR: wr_new = wr_old & ~wr_src_i;
      default:   wr_new = wr_old;
    endcase
    wr_ok = wr_en_i && !trap_i && !mret_i && (op_kind != OPK_NONE) &&
            !(((op_kind == OPK_SET) || (op_kind == OPK_CLEAR)) && wr_src_zero_i);
  end

  // Next-state for all registers. Counters advance regardless of trap/mret;
  // an explicit write to a counter replaces that cycle's increment.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {{(XLEN-1){1'b0}}, retire_i};

    if (trap_i) begin
      mepc_d         = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d       = trap_cause_i;
      mtval_d        = trap_tval_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_ok) begin
      case (wr_idx_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wr_new[MSTATUS_MIE_BIT];
          mstatus_mpie_d = wr_new[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = wr_new;
        CSR_MTVEC:    mtvec_d    = {wr_new[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = wr_new;
        CSR_MEPC:     mepc_d     = {wr_new[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wr_new;
        CSR_MTVAL:    mtval_d    = wr_new;
        CSR_MCYCLE:   mcycle_d   = wr_new;
        CSR_MINSTRET: minstret_d = wr_new;
        default: ;
      endcase
    end
  end

  // State registers; reset wins over every same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign trap_vec_o    = mtvec_q;
  assign mret_pc_o     = mepc_q;
  assign mstatus_mie_o = mstatus_mie_q;

endmodule
